// File: rtl/game_pkg.sv
// Shared game-logic definitions: action bit positions, player slot count and
// the scheduler state encoding.
package game_pkg;
  localparam int MAX_PLAYERS = 4;

  localparam int BTN_LEFT  = 0;
  localparam int BTN_RIGHT = 1;
  localparam int BTN_UP    = 2;
  localparam int BTN_DOWN  = 3;
  localparam int BTN_CHOP  = 4;
  localparam int BTN_CARRY = 5;

  typedef enum logic [1:0] {IDLE, SCAN, WAIT, DONE} sched_state_t;
endpackage

// File: rtl/player_action_scheduler_if.sv
// Action handshake from the scheduler to the grid-update datapath.
interface player_action_scheduler_if #(
  parameter int PW    = 2,
  parameter int BTN_W = 6
);
  logic             act_valid;
  logic [PW-1:0]    act_player;
  logic [BTN_W-1:0] act_buttons;
  logic             act_ready;

  modport master (output act_valid, act_player, act_buttons, input act_ready);
  modport slave  (input act_valid, act_player, act_buttons, output act_ready);
endinterface

// File: rtl/player_action_scheduler_rr_index.sv
// Wrapping increment of a player index modulo the active player count.
module rr_index #(
  parameter int PW = 2
)(
  input  logic [PW-1:0] i_idx,
  input  logic [PW:0]   i_cnt,
  output logic [PW-1:0] o_next
);
  always_comb begin
    o_next = i_idx + PW'(1);
    if ({1'b0, i_idx} == i_cnt - (PW+1)'(1)) o_next = '0;
  end
endmodule

// File: rtl/player_action_scheduler.sv
// Per-frame round-robin scheduler that offers each active player's snapshot
// actions to the shared grid-update datapath over a valid/ready handshake.
module player_action_scheduler #(
  parameter int  MAX_PLAYERS = game_pkg::MAX_PLAYERS,
  parameter int  BTN_W       = 6,
  parameter int  TIMEOUT     = 255,
  parameter int  SKIP_IDLE   = 1,
  localparam int PW          = $clog2(MAX_PLAYERS)
)(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         frame_update,
  input  logic [PW-1:0]                num_players,
  input  logic [MAX_PLAYERS*BTN_W-1:0] player_buttons,
  player_action_scheduler_if.master    act_if,
  output logic                         busy,
  output logic                         sweep_done,
  output logic                         timeout_pulse,
  output logic                         overrun_pulse
);
  import game_pkg::*;

  localparam int TW = $clog2(TIMEOUT + 1);

  sched_state_t                      r_state, w_state_nxt;
  logic [MAX_PLAYERS-1:0][BTN_W-1:0] r_snap;
  logic [MAX_PLAYERS-1:0]            w_nonzero;
  logic [PW:0]                       r_active, r_served, w_new_cnt;
  logic [PW-1:0]                     r_idx, r_start_ptr;
  logic [PW-1:0]                     w_idx_adv, w_ptr_adv, w_start_mod;
  logic [TW-1:0]                     r_wcnt;
  logic [PW-1:0]                     r_player;
  logic [BTN_W-1:0]                  r_buttons;
  logic                              r_timeout, r_overrun;
  logic                              w_start, w_skip, w_issue, w_xfer, w_drop, w_done;

  for (genvar p = 0; p < MAX_PLAYERS; p++) begin : g_nz
    assign w_nonzero[p] = |r_snap[p];
  end

  // A stale start pointer from a larger previous sweep is folded into range here.
  assign w_new_cnt   = {1'b0, num_players} + (PW+1)'(1);
  assign w_start_mod = PW'({1'b0, r_start_ptr} % w_new_cnt);

  rr_index #(.PW(PW)) u_idx_adv (.i_idx(r_idx),       .i_cnt(r_active), .o_next(w_idx_adv));
  rr_index #(.PW(PW)) u_ptr_adv (.i_idx(r_start_ptr), .i_cnt(r_active), .o_next(w_ptr_adv));

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_skip      = 1'b0;
    w_issue     = 1'b0;
    w_xfer      = 1'b0;
    w_drop      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      IDLE: if (frame_update) begin
        w_start     = 1'b1;
        w_state_nxt = SCAN;
      end
      SCAN: begin
        if (r_served == r_active)                          w_state_nxt = DONE;
        else if ((SKIP_IDLE != 0) && !w_nonzero[r_idx])    w_skip = 1'b1;
        else begin
          w_issue     = 1'b1;
          w_state_nxt = WAIT;
        end
      end
      // Ready is checked first so an accept on the last wait cycle is not dropped.
      WAIT: begin
        if (act_if.act_ready) begin
          w_xfer      = 1'b1;
          w_state_nxt = SCAN;
        end else if (r_wcnt == TW'(TIMEOUT - 1)) begin
          w_drop      = 1'b1;
          w_state_nxt = SCAN;
        end
      end
      DONE: begin
        w_done      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_snap      <= '0;
      r_active    <= (PW+1)'(1);
      r_served    <= '0;
      r_idx       <= '0;
      r_start_ptr <= '0;
      r_wcnt      <= '0;
      r_player    <= '0;
      r_buttons   <= '0;
      r_timeout   <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_timeout <= w_drop;
      r_overrun <= frame_update && (r_state != IDLE);
      if (w_start) begin
        r_snap      <= player_buttons;
        r_active    <= w_new_cnt;
        r_idx       <= w_start_mod;
        r_start_ptr <= w_start_mod;
        r_served    <= '0;
        r_wcnt      <= '0;
      end
      if (w_skip || w_xfer || w_drop) begin
        r_idx    <= w_idx_adv;
        r_served <= r_served + (PW+1)'(1);
        r_wcnt   <= '0;
      end
      if (w_issue) begin
        r_player  <= r_idx;
        r_buttons <= r_snap[r_idx];
        r_wcnt    <= '0;
      end
      if ((r_state == WAIT) && !w_xfer && !w_drop) r_wcnt <= r_wcnt + TW'(1);
      if (w_done) r_start_ptr <= w_ptr_adv;
    end
  end

  assign act_if.act_valid   = (r_state == WAIT);
  assign act_if.act_player  = r_player;
  assign act_if.act_buttons = r_buttons;
  assign busy               = (r_state != IDLE);
  assign sweep_done         = (r_state == DONE);
  assign timeout_pulse      = r_timeout;
  assign overrun_pulse      = r_overrun;
endmodule

// File: tb/tb_player_action_scheduler.sv
// Directed bench for player_action_scheduler: rotation, skip, timeout,
// overrun and asynchronous reset behaviour against hand-computed values.
module tb_player_action_scheduler;
  logic        clock, reset, frame_update;
  logic [1:0]  num_players;
  logic [23:0] player_buttons;
  logic        busy, sweep_done, timeout_pulse, overrun_pulse;
  logic [5:0]  bexp [4];
  int          seen [$];
  int          n_chk, n_pass;

  player_action_scheduler_if act_if();

  player_action_scheduler dut (
    .clock          (clock),
    .reset          (reset),
    .frame_update   (frame_update),
    .num_players    (num_players),
    .player_buttons (player_buttons),
    .act_if         (act_if),
    .busy           (busy),
    .sweep_done     (sweep_done),
    .timeout_pulse  (timeout_pulse),
    .overrun_pulse  (overrun_pulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_btns();
    player_buttons = {bexp[3], bexp[2], bexp[1], bexp[0]};
  endtask

  // Pulses frame_update with act_ready high and records the service order.
  task automatic run_sweep(input string tag, input int exp_ord[4], input int n_ord,
                           input int exp_lat);
    int lat, fv;
    bit done;
    seen.delete();
    lat = 0; fv = 0; done = 0;
    frame_update = 1'b1;
    for (int c = 1; c <= 64 && !done; c++) begin
      tick();
      if (c == 1) begin
        frame_update = 1'b0;
        chk({tag, "_busy"}, busy, 1);
      end
      if (act_if.act_valid) begin
        if (fv == 0) fv = c;
        seen.push_back(int'(act_if.act_player));
        chk({tag, "_btn"}, act_if.act_buttons, bexp[act_if.act_player]);
      end
      if (sweep_done) begin
        done = 1;
        lat  = c;
      end
    end
    chk({tag, "_finished"}, done, 1);
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_first_valid"}, fv, 2);
    chk({tag, "_count"}, seen.size(), n_ord);
    for (int i = 0; i < n_ord && i < seen.size(); i++)
      chk({tag, "_order"}, seen[i], exp_ord[i]);
    tick();
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    int cnt;
    n_chk = 0; n_pass = 0;
    reset = 1'b1; frame_update = 1'b0; num_players = 2'd0;
    player_buttons = '0; act_if.act_ready = 1'b0;
    for (int i = 0; i < 4; i++) bexp[i] = '0;
    tick(); tick();
    chk("rst_valid", act_if.act_valid, 0);
    chk("rst_player", act_if.act_player, 0);
    chk("rst_buttons", act_if.act_buttons, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", sweep_done, 0);
    chk("rst_timeout", timeout_pulse, 0);
    chk("rst_overrun", overrun_pulse, 0);
    reset = 1'b0;
    tick();

    // One player, always ready
    bexp[0] = 6'b000001; apply_btns();
    num_players = 2'd0; act_if.act_ready = 1'b1;
    run_sweep("one", '{0, 0, 0, 0}, 1, 4);

    // Four players, rotating start across three frames
    bexp[0] = 6'b000011; bexp[1] = 6'b000100; bexp[2] = 6'b101000; bexp[3] = 6'b010000;
    apply_btns(); num_players = 2'd3;
    run_sweep("rot0", '{0, 1, 2, 3}, 4, 10);
    run_sweep("rot1", '{1, 2, 3, 0}, 4, 10);
    run_sweep("rot2", '{2, 3, 0, 1}, 4, 10);

    // Three players with p1 idle; start pointer 3 folds to 0
    bexp[0] = 6'b100001; bexp[1] = 6'b000000; bexp[2] = 6'b000010; bexp[3] = 6'b111111;
    apply_btns(); num_players = 2'd2;
    run_sweep("skip", '{0, 2, 0, 0}, 2, 7);

    // Timeout: start pointer 1 mod 2 -> player 1 first
    bexp[0] = 6'b010000; bexp[1] = 6'b100010; apply_btns();
    num_players = 2'd1; act_if.act_ready = 1'b0;
    frame_update = 1'b1; tick(); frame_update = 1'b0;
    tick();
    chk("to_valid", act_if.act_valid, 1);
    chk("to_player", act_if.act_player, 1);
    cnt = 1;
    for (int c = 0; c < 400 && act_if.act_valid; c++) begin
      tick();
      if (act_if.act_valid) cnt++;
    end
    chk("to_len", cnt, 255);
    chk("to_pulse", timeout_pulse, 1);
    tick();
    chk("to_next_valid", act_if.act_valid, 1);
    chk("to_next_player", act_if.act_player, 0);
    chk("to_pulse_once", timeout_pulse, 0);
    act_if.act_ready = 1'b1;
    tick(); tick();
    chk("to_done", sweep_done, 1);
    tick();

    // Overrun during WAIT and during DONE
    bexp[0] = 6'b000100; bexp[1] = 6'b001000; apply_btns();
    act_if.act_ready = 1'b0;
    frame_update = 1'b1; tick(); frame_update = 1'b0;
    tick();
    chk("ov_player", act_if.act_player, 0);
    chk("ov_btn", act_if.act_buttons, 6'b000100);
    player_buttons = '1;
    frame_update = 1'b1; tick(); frame_update = 1'b0;
    chk("ov_wait_pulse", overrun_pulse, 1);
    chk("ov_wait_valid", act_if.act_valid, 1);
    chk("ov_wait_btn", act_if.act_buttons, 6'b000100);
    act_if.act_ready = 1'b1;
    tick();
    chk("ov_pulse_clear", overrun_pulse, 0);
    tick();
    chk("ov_p1_player", act_if.act_player, 1);
    chk("ov_p1_snapshot", act_if.act_buttons, 6'b001000);
    tick(); tick();
    chk("ov_in_done", sweep_done, 1);
    frame_update = 1'b1; tick(); frame_update = 1'b0;
    chk("ov_done_pulse", overrun_pulse, 1);
    chk("ov_done_ignored", busy, 0);
    tick();
    chk("ov_still_idle", busy, 0);

    // Asynchronous reset mid-WAIT; start pointer 1 mod 4 -> player 1 first
    bexp[0] = 6'b000001; bexp[1] = 6'b000010; bexp[2] = 6'b000100; bexp[3] = 6'b001000;
    apply_btns(); num_players = 2'd3; act_if.act_ready = 1'b0;
    frame_update = 1'b1; tick(); frame_update = 1'b0;
    tick();
    chk("ar_valid", act_if.act_valid, 1);
    chk("ar_player", act_if.act_player, 1);
    #2 reset = 1'b1;
    #1;
    chk("ar_valid_drop", act_if.act_valid, 0);
    chk("ar_busy_drop", busy, 0);
    chk("ar_player_clr", act_if.act_player, 0);
    #2 reset = 1'b0;
    tick();
    act_if.act_ready = 1'b1;
    run_sweep("post_rst", '{0, 1, 2, 3}, 4, 10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/player_action_scheduler.md
Name: player_action_scheduler

Overview:
- Per-frame scheduler that shares the single game-logic grid-update datapath between up to four players.
- On each `frame_update` pulse it snapshots every player's debounced buttons and carry switch.
- It then presents the active players to the datapath one at a time over a valid/ready handshake.
- The starting player rotates each frame for fairness.
- Sits between the debounce/network input layer and `game_logic`.

Parameters:
- MAX_PLAYERS, 4, number of player slots; sets the width of `player_buttons` and the index width.
- BTN_W, 6, action bits per player: {carry, chop, down, up, right, left}, bit 0 = left.
- TIMEOUT, 255, cycles to wait for `act_ready` before dropping the current action.
- SKIP_IDLE, 1, when 1 a player whose snapshot is all-zero is not issued.

Ports:
- clock  input  1  system clock, 25 MHz pixel clock domain.
- reset  input  1  asynchronous, active-high; all state cleared immediately on assertion.
- frame_update  input  1  one-cycle pulse marking the start of a frame; starts a sweep.
- num_players  input  2  active players minus one (0 = 1 player, 3 = 4 players); sampled at sweep start.
- player_buttons  input  MAX_PLAYERS*BTN_W  packed actions; player p occupies [p*BTN_W +: BTN_W].
- act_valid  output  1  an action is offered to the datapath.
- act_player  output  2  player index of the offered action.
- act_buttons  output  BTN_W  snapshot buttons of the offered player.
- act_ready  input  1  datapath accepts the action in this cycle.
- busy  output  1  high while a sweep is in progress (state ≠ IDLE).
- sweep_done  output  1  one-cycle pulse when a sweep completes.
- timeout_pulse  output  1  one-cycle pulse when an action is dropped on timeout.
- overrun_pulse  output  1  one-cycle pulse when `frame_update` arrives while busy.

Behaviour:
- Reset values:
  - state = IDLE; start_ptr = 0; snapshot = 0.
  - act_valid = 0, act_player = 0, act_buttons = 0.
  - busy = 0, sweep_done = 0, timeout_pulse = 0, overrun_pulse = 0.
- State machine:
  - IDLE:
    - On `frame_update` at edge t: capture `player_buttons` into snapshot and `num_players+1` into active_cnt.
    - Set idx = start_ptr mod active_cnt and served = 0, then go to SCAN.
  - SCAN:
    - If served == active_cnt, go to DONE.
    - Else if SKIP_IDLE and snapshot[idx] == 0: advance idx, served += 1, stay in SCAN. This costs one cycle per skipped player.
    - Else go to WAIT with act_player = idx and act_buttons = snapshot[idx].
  - WAIT:
    - `act_valid` = 1; `act_player` and `act_buttons` are held stable.
    - `act_ready` high: transfer completes on that edge; advance idx, served += 1, clear the wait counter, go to SCAN.
    - The wait counter reaches TIMEOUT without `act_ready`: pulse `timeout_pulse`, drop the action, advance, go to SCAN.
    - `act_ready` wins over timeout when both occur in the same cycle.
  - DONE:
    - Pulse `sweep_done`.
    - start_ptr = (start_ptr + 1) mod active_cnt, wrapping from active_cnt−1 to 0.
    - Go to IDLE.
- Index advance: idx = (idx == active_cnt−1) ? 0 : idx + 1.
- Latency: `frame_update` sampled at edge t → `act_valid` first visible in cycle t+2 (no skips). Each accepted transfer takes ≥2 cycles: WAIT then SCAN.
- `act_valid` is never deasserted without a transfer, a timeout, or reset.
- `frame_update` while state ≠ IDLE:
  - It is ignored; no re-snapshot, and the sweep continues.
  - `overrun_pulse` fires on the next cycle.
- `frame_update` coinciding with the DONE cycle is also an overrun, and it is ignored.
- `num_players` or `player_buttons` changing mid-sweep has no effect; only snapshot values are used.
- start_ptr ≥ a new active_cnt: it is reduced mod active_cnt at sweep start.
- Reset mid-sweep (including during WAIT): outputs drop to reset values asynchronously. No partial sweep resumes.
- Buttons are used as snapshot levels. No edge detection in this block.

Decomposition:
- Shared package `game_pkg`:
  - Action bit positions: BTN_LEFT = 0, BTN_RIGHT, BTN_UP, BTN_DOWN, BTN_CHOP, BTN_CARRY = 5.
  - MAX_PLAYERS.
  - Enum `sched_state_t` {IDLE, SCAN, WAIT, DONE}.
- One natural sub-module: `rr_index` (wrapping index / start-pointer incrementer mod active_cnt). Everything else stays inline.

Test Plan:
- 1 player, num_players = 0, buttons p0 = 6'b000001, `act_ready` tied 1, pulse `frame_update` at cycle 10 → act_valid at 12 with player 0 / buttons 000001; sweep_done at 14; busy high for cycles 11–14.
- 4 players, all non-zero, `act_ready` = 1, three consecutive frames → service order 0,1,2,3 then 1,2,3,0 then 2,3,0,1.
- 3 players, p1 = 0, SKIP_IDLE = 1 → only players 0 and 2 are offered; the skip costs one cycle.
- `act_ready` held 0, TIMEOUT = 255 → act_valid high for exactly 255 cycles, one timeout_pulse, then the next player is offered.
- `frame_update` pulsed during WAIT, and again in the DONE cycle → overrun_pulse each time; snapshot unchanged.
- Reset asserted mid-WAIT while act_valid = 1 → act_valid = 0 and busy = 0 without a clock edge; the next frame starts from player 0.
